wb_sram_responder: RTL and testbench

- Wishbone B4 pipelined responder (slave) that serves a word-addressed on-chip SRAM to a Wishbone initiator such as the two-way set-associative cache.
- Adds the following to a plain memory:
  - a configurable response latency;
  - an outstanding-request limit driven through stall;
  - out-of-range error responses;
  - abort on cyc drop.
- Used as the backing store behind the cache. It also exercises the initiator's stall, ack and err handling.

---
 rtl/wb_sram_responder.sv | 109 ++++++++++
 tb/tb_wb_sram_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_responder.sv
// Wishbone B4 pipelined responder in front of a word-addressed on-chip SRAM.
// Adds fixed response latency, an outstanding-request limit via stall, range errors and cyc abort.
module wb_sram_responder #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MAX_OUT   = 2,
  parameter bit          FILE_LOAD = 1'b0,
  parameter string       FILE      = ""
) (
  input  logic            cpu_clock_i,
  input  logic            reset_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_stall_o,
  output logic            wb_ack_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_err_o
);

  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [DW-1:0] mem [MEM_WORDS];

  logic          accept;
  logic          in_range;
  logic          respond;
  logic [IW-1:0] idx;
  logic [DW-1:0] rdata_in;

  logic [CW-1:0]      count_q, count_d;
  logic [LATENCY-1:0] pipe_vld_q;
  logic [LATENCY-1:0] pipe_err_q;
  logic [DW-1:0]      pipe_dat_q [LATENCY];
  logic               ack_q, err_q;
  logic [DW-1:0]      dat_q;

  assign wb_stall_o = (count_q == CW'(MAX_OUT));
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign in_range   = (32'(wb_adr_i) < MEM_WORDS);
  assign idx        = wb_adr_i[IW-1:0];
  assign rdata_in   = (in_range && !wb_we_i) ? mem[idx] : '0;

  // A request retires from the count as it enters the last stage, one edge before its
  // ack is visible; this is what lets MAX_OUT == LATENCY stream one request per cycle.
  if (LATENCY > 1) begin : g_retire
    assign respond = pipe_vld_q[LATENCY-2];
  end else begin : g_retire_now
    assign respond = accept;
  end

  always_comb begin
    count_d = count_q;
    if (accept && !respond) begin
      count_d = count_q + CW'(1);
    end else if (!accept && respond) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (accept && !reset_i && wb_we_i && in_range) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (wb_sel_i[b]) begin
          mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (reset_i || !wb_cyc_i) begin
      count_q    <= '0;
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_dat_q[i] <= '0;
      end
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      count_q       <= count_d;
      pipe_vld_q[0] <= accept;
      pipe_err_q[0] <= accept & ~in_range;
      pipe_dat_q[0] <= accept ? rdata_in : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
      ack_q <= pipe_vld_q[LATENCY-1] & ~pipe_err_q[LATENCY-1];
      err_q <= pipe_vld_q[LATENCY-1] & pipe_err_q[LATENCY-1];
      dat_q <= (pipe_vld_q[LATENCY-1] && !pipe_err_q[LATENCY-1]) ?
               pipe_dat_q[LATENCY-1] : '0;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench: instance a (LATENCY=2, MAX_OUT=2) for data paths, errors and abort;
// instance b (LATENCY=3, MAX_OUT=1) for stall pacing. Both use a 16-word memory.
module tb_wb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_cyc, a_stb, a_we, a_stall, a_ack, a_err;
  logic [4:0]  a_adr;
  logic [31:0] a_wdat, a_rdat;
  logic [3:0]  a_sel;
  logic        b_cyc, b_stb, b_we, b_stall, b_ack, b_err;
  logic [4:0]  b_adr;
  logic [31:0] b_wdat, b_rdat;
  logic [3:0]  b_sel;

  int n_tests = 0;
  int n_fail  = 0;

  wb_sram_responder #(
    .AW(5), .DW(32), .MEM_WORDS(16), .LATENCY(2), .MAX_OUT(2), .FILE_LOAD(1'b0), .FILE("")
  ) dut_a (
    .cpu_clock_i(clk), .reset_i(rst), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(a_we),
    .wb_adr_i(a_adr), .wb_dat_i(a_wdat), .wb_sel_i(a_sel), .wb_stall_o(a_stall),
    .wb_ack_o(a_ack), .wb_dat_o(a_rdat), .wb_err_o(a_err)
  );

  wb_sram_responder #(
    .AW(5), .DW(32), .MEM_WORDS(16), .LATENCY(3), .MAX_OUT(1), .FILE_LOAD(1'b0), .FILE("")
  ) dut_b (
    .cpu_clock_i(clk), .reset_i(rst), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(b_we),
    .wb_adr_i(b_adr), .wb_dat_i(b_wdat), .wb_sel_i(b_sel), .wb_stall_o(b_stall),
    .wb_ack_o(b_ack), .wb_dat_o(b_rdat), .wb_err_o(b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance a or b; lat counts edges from the accept edge to the response.
  task automatic xfer(input bit use_b, input bit we, input logic [4:0] adr,
                      input logic [31:0] wd, input logic [3:0] sel,
                      output logic ack, output logic err, output logic [31:0] rd,
                      output int lat);
    if (use_b) begin
      b_cyc = 1'b1; b_stb = 1'b1; b_we = we; b_adr = adr; b_wdat = wd; b_sel = sel;
    end else begin
      a_cyc = 1'b1; a_stb = 1'b1; a_we = we; a_adr = adr; a_wdat = wd; a_sel = sel;
    end
    for (int k = 0; k < 20 && (use_b ? b_stall : a_stall); k++) tick();
    tick();
    a_stb = 1'b0;
    b_stb = 1'b0;
    ack = 1'b0; err = 1'b0; rd = '0; lat = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (use_b ? (b_ack | b_err) : (a_ack | a_err)) begin
        ack = use_b ? b_ack : a_ack;
        err = use_b ? b_err : a_err;
        rd  = use_b ? b_rdat : a_rdat;
        lat = k;
        break;
      end
    end
  endtask

  logic        ack, err;
  logic [31:0] rd;
  int          lat;
  int          nacc, nack, first, last, maxc;
  bit          acc_now;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_cyc = 0; a_stb = 0; a_we = 0; a_adr = 0; a_wdat = 0; a_sel = 0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = 0; b_wdat = 0; b_sel = 0;
    repeat (3) tick();
    check_eq("rst_ack", a_ack, 0);
    check_eq("rst_err", a_err, 0);
    check_eq("rst_dat", a_rdat, 0);
    check_eq("rst_stall_a", a_stall, 0);
    check_eq("rst_stall_b", b_stall, 0);
    rst = 1'b0;
    tick();

    xfer(0, 1, 5'd5, 32'hDEADBEEF, 4'hF, ack, err, rd, lat);
    check_eq("wr5_ack", ack, 1);
    check_eq("wr5_dat", rd, 0);
    check_eq("wr5_lat", lat, 2);
    xfer(0, 0, 5'd5, 0, 4'hF, ack, err, rd, lat);
    check_eq("rd5_ack", ack, 1);
    check_eq("rd5_err", err, 0);
    check_eq("rd5_dat", rd, 32'hDEADBEEF);
    check_eq("rd5_lat", lat, 2);
    tick();
    check_eq("rd5_ack_one_cycle", a_ack, 0);

    xfer(0, 1, 5'd7, 32'hAABBCCDD, 4'hF, ack, err, rd, lat);
    xfer(0, 1, 5'd7, 32'h11223344, 4'b0101, ack, err, rd, lat);
    check_eq("wr7_lane_ack", ack, 1);
    check_eq("wr7_lane_dat", rd, 0);
    xfer(0, 0, 5'd7, 0, 4'hF, ack, err, rd, lat);
    check_eq("rd7_lanes", rd, 32'hAA22CC44);
    xfer(0, 1, 5'd7, 32'hFFFFFFFF, 4'h0, ack, err, rd, lat);
    check_eq("wr7_sel0_ack", ack, 1);
    xfer(0, 0, 5'd7, 0, 4'hF, ack, err, rd, lat);
    check_eq("rd7_after_sel0", rd, 32'hAA22CC44);

    xfer(0, 1, 5'd4, 32'h44444444, 4'hF, ack, err, rd, lat);
    for (int i = 0; i < 4; i++) xfer(0, 1, 5'(8 + i), 32'hA0A00000 + i, 4'hF, ack, err, rd, lat);

    // Four back-to-back reads of adrs 8..11.
    nack = 0; first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      a_cyc = 1'b1;
      if (i < 4) begin
        a_stb = 1'b1; a_we = 1'b0; a_adr = 5'(8 + i);
        check_eq("b2b_stall", a_stall, 0);
      end else begin
        a_stb = 1'b0;
      end
      tick();
      if (a_ack) begin
        if (nack < 4) check_eq("b2b_data", a_rdat, 32'hA0A00000 + nack);
        if (nack == 0) first = i;
        last = i;
        nack++;
      end
    end
    check_eq("b2b_count", nack, 4);
    check_eq("b2b_first", first, 2);
    check_eq("b2b_last", last, 5);

    xfer(0, 0, 5'd16, 0, 4'hF, ack, err, rd, lat);
    check_eq("oor_rd_err", err, 1);
    check_eq("oor_rd_ack", ack, 0);
    check_eq("oor_rd_dat", rd, 0);
    check_eq("oor_rd_lat", lat, 2);
    xfer(0, 1, 5'd20, 32'hFFFFFFFF, 4'hF, ack, err, rd, lat);
    check_eq("oor_wr_err", err, 1);
    check_eq("oor_wr_ack", ack, 0);
    check_eq("oor_wr_dat", rd, 0);
    xfer(0, 0, 5'd4, 0, 4'hF, ack, err, rd, lat);
    check_eq("oor_mem_kept", rd, 32'h44444444);

    // Abort by dropping cyc with a read and a write in flight.
    xfer(0, 1, 5'd3, 32'h0, 4'hF, ack, err, rd, lat);
    a_stb = 1'b1; a_we = 1'b0; a_adr = 5'd0;
    tick();
    a_we = 1'b1; a_adr = 5'd3; a_wdat = 32'h5; a_sel = 4'hF;
    tick();
    a_cyc = 1'b0; a_stb = 1'b0;
    tick();
    check_eq("abort_count", dut_a.count_q, 0);
    a_cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_resp", a_ack | a_err, 0);
      tick();
    end
    xfer(0, 0, 5'd3, 0, 4'hF, ack, err, rd, lat);
    check_eq("abort_wr_kept", rd, 32'h5);

    // Same, but reset mid-flight with cyc kept high.
    xfer(0, 1, 5'd3, 32'h0, 4'hF, ack, err, rd, lat);
    a_stb = 1'b1; a_we = 1'b0; a_adr = 5'd0;
    tick();
    a_we = 1'b1; a_adr = 5'd3; a_wdat = 32'h5; a_sel = 4'hF;
    tick();
    a_stb = 1'b0; rst = 1'b1;
    tick();
    check_eq("rstmid_ack", a_ack, 0);
    check_eq("rstmid_err", a_err, 0);
    check_eq("rstmid_dat", a_rdat, 0);
    check_eq("rstmid_stall", a_stall, 0);
    check_eq("rstmid_count", dut_a.count_q, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rstmid_no_resp", a_ack | a_err, 0);
    end
    xfer(0, 0, 5'd3, 0, 4'hF, ack, err, rd, lat);
    check_eq("rstmid_wr_kept", rd, 32'h5);

    // Instance b: stb held high for reads of 0,1,2 with MAX_OUT=1, LATENCY=3.
    for (int i = 0; i < 3; i++) xfer(1, 1, 5'(i), 32'hB0 + i, 4'hF, ack, err, rd, lat);
    nacc = 0; nack = 0; maxc = 0;
    b_cyc = 1'b1; b_we = 1'b0;
    for (int i = 0; i < 15; i++) begin
      b_stb = (nacc < 3);
      b_adr = 5'(nacc);
      acc_now = b_stb && !b_stall;
      tick();
      if (acc_now) begin
        check_eq("pace_accept_cycle", i, 3 * nacc);
        nacc++;
      end
      if (b_ack) begin
        check_eq("pace_ack_cycle", i, 3 * nack + 3);
        check_eq("pace_ack_data", b_rdat, 32'hB0 + nack);
        nack++;
      end
      if (int'(dut_b.count_q) > maxc) maxc = int'(dut_b.count_q);
    end
    check_eq("pace_accepts", nacc, 3);
    check_eq("pace_acks", nack, 3);
    check_eq("pace_count_le1", (maxc <= 1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
